uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART byte transmitter between two byte sources, for example the echo path and a status/diagnostic path. Each source writes bytes into its own small FIFO. The arbiter picks one byte at a time and launches it on the transmitter with a one-cycle start strobe. It then holds off until the transmitter's end flag has both risen and fallen before it launches the next byte. The block sits between the requesters and the transmitter's `start`/data/`TX_END` pins. It does not touch the bit timing.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_byte_fifo.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 79 +++++++
 tb/tb_uart_tx_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and sizing constants for the UART transmit arbiter
package uart_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      START    = 2'd1,
      WAIT_END = 2'd2,
      WAIT_CLR = 2'd3
   } state_t;
   localparam int BYTE_W    = 8;
   localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: small byte FIFO with push-side overflow flag; a push is judged against the registered count
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [BYTE_W-1:0]     data_i,
   input  logic                  pop_i,
   output logic [BYTE_W-1:0]     head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  ovf_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] cnt_q;
   logic ovf_q;
   logic do_push, do_pop;
   assign full_o  = cnt_q == FULL;
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign ovf_o   = ovf_q;
   assign head_o  = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   // pointers and count; pointers wrap naturally at DEPTH, overflow is sticky until reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
         ovf_q <= ovf_q | (push_i & full_o);
      end
   end
   // storage needs no reset: the count alone defines which entries are valid
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin launch of bytes from two FIFOs onto one UART transmitter
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ch0_wr_i,
   input  logic [BYTE_W-1:0] ch0_data_i,
   output logic              ch0_full_o,
   input  logic              ch1_wr_i,
   input  logic [BYTE_W-1:0] ch1_data_i,
   output logic              ch1_full_o,
   output logic [1:0]        ovf_o,
   output logic              tx_start_o,
   output logic [BYTE_W-1:0] tx_data_o,
   input  logic              tx_end_i,
   output logic              busy_o,
   output logic              grant_o
);
   state_t state_q, state_d;
   logic last_q, last_d, grant_q, grant_d, start_q, busy_q, sel;
   logic [BYTE_W-1:0] data_q, data_d, head0, head1;
   logic [1:0] pop, empty, ne;
   logic [$clog2(DEPTH):0] unused_cnt0, unused_cnt1;
   uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(ch0_wr_i), .data_i(ch0_data_i), .pop_i(pop[0]),
      .head_o(head0), .count_o(unused_cnt0), .full_o(ch0_full_o), .empty_o(empty[0]), .ovf_o(ovf_o[0])
   );
   uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(ch1_wr_i), .data_i(ch1_data_i), .pop_i(pop[1]),
      .head_o(head1), .count_o(unused_cnt1), .full_o(ch1_full_o), .empty_o(empty[1]), .ovf_o(ovf_o[1])
   );
   assign ne         = ~empty;
   assign sel        = &ne ? ~last_q : ne[1];
   assign tx_start_o = start_q;
   assign tx_data_o  = data_q;
   assign busy_o     = busy_q;
   assign grant_o    = grant_q;
   // next state: grant and pop in IDLE, then wait for the end flag to rise and fall again
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      data_d  = data_q;
      pop     = '0;
      case (state_q)
         IDLE: if (|ne) begin
            pop[sel] = 1'b1;
            data_d   = sel ? head1 : head0;
            grant_d  = sel;
            last_d   = sel;
            state_d  = START;
         end
         START:    state_d = WAIT_END;
         WAIT_END: state_d = tx_end_i ? WAIT_CLR : WAIT_END;
         WAIT_CLR: state_d = tx_end_i ? WAIT_CLR : IDLE;
      endcase
   end
   // state and registered outputs; last resets to 1 so channel 0 wins the first tie
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         grant_q <= 1'b0;
         data_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         start_q <= state_d == START;
         busy_q  <= state_d != IDLE;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus random traffic against a queue-based transaction model
module tb_uart_tx_arbiter;
   localparam int DEPTH = 4;
   logic clk = 0, rst = 1;
   logic ch0_wr = 0, ch1_wr = 0, tx_end = 0;
   logic [7:0] ch0_data = 0, ch1_data = 0;
   logic ch0_full, ch1_full, tx_start, busy, grant;
   logic [1:0] ovf;
   logic [7:0] tx_data;
   int checks = 0, failures = 0, cyc = 0;

   uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .ch0_wr_i(ch0_wr), .ch0_data_i(ch0_data), .ch0_full_o(ch0_full),
      .ch1_wr_i(ch1_wr), .ch1_data_i(ch1_data), .ch1_full_o(ch1_full), .ovf_o(ovf),
      .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_end_i(tx_end), .busy_o(busy), .grant_o(grant)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // transaction model: per-channel queues, one byte in flight, completion = end flag seen high then low
   logic [7:0] mq0[$], mq1[$];
   logic m_out = 0, m_rose = 0, m_last = 1, m_grant = 0, m_start = 0, w;
   logic [7:0] m_data = 0;
   logic [1:0] m_ovf = 0;
   int m_edge = 0, m_launch = 0, n0, n1;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq0.delete(); mq1.delete();
         m_out = 0; m_rose = 0; m_last = 1; m_grant = 0; m_start = 0; m_data = 0; m_ovf = 0;
         m_edge = 0; m_launch = 0;
      end else begin
         n0 = mq0.size(); n1 = mq1.size();
         m_edge++;
         m_start = 0;
         if (m_out) begin
            if (!m_rose) begin
               if (tx_end && m_edge >= m_launch + 2) m_rose = 1;
            end else if (!tx_end) m_out = 0;
         end else if (n0 + n1 > 0) begin
            w = (n0 > 0 && n1 > 0) ? !m_last : (n1 > 0);
            m_data = w ? mq1.pop_front() : mq0.pop_front();
            m_grant = w; m_last = w; m_out = 1; m_rose = 0; m_launch = m_edge; m_start = 1;
         end
         if (ch0_wr) begin
            if (n0 < DEPTH) mq0.push_back(ch0_data); else m_ovf[0] = 1;
         end
         if (ch1_wr) begin
            if (n1 < DEPTH) mq1.push_back(ch1_data); else m_ovf[1] = 1;
         end
      end
   end

   // transmitter model: end flag rises a delay after start and stays high for a hold time
   int tx_delay = 3, tx_hold = 2, tx_cnt = 0, tx_hcnt = 0, kick_req = 0, kick_ack = 0, fall_cyc = 0;
   logic tx_stall = 0, rnd_tx = 0;
   always @(negedge clk) begin
      if (tx_hcnt > 0) begin
         tx_hcnt--;
         if (tx_hcnt == 0) begin tx_end = 0; fall_cyc = cyc; end
      end else if (tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0) begin tx_end = 1; tx_hcnt = rnd_tx ? int'($urandom_range(1, 4)) : tx_hold; end
      end
      if (kick_req != kick_ack) begin kick_ack = kick_req; tx_cnt = 1; end
      if (tx_start && !tx_stall) tx_cnt = rnd_tx ? int'($urandom_range(1, 5)) : tx_delay;
   end

   // launch log taken from the DUT start strobe
   logic [7:0] log_d[$];
   logic log_g[$];
   int log_c[$];
   always @(negedge clk) if (tx_start) begin log_d.push_back(tx_data); log_g.push_back(grant); log_c.push_back(cyc); end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic w0, input logic [7:0] d0, input logic w1, input logic [7:0] d1);
      ch0_wr = w0; ch0_data = d0; ch1_wr = w1; ch1_data = d1;
      @(negedge clk);
      ch0_wr = 0; ch1_wr = 0;
   endtask

   task automatic wait_idle(input int maxc, output int at);
      int k = 0;
      while ((busy || mq0.size() + mq1.size() > 0) && k < maxc) begin @(negedge clk); k++; end
      at = cyc;
      chk("idle_reached", k < maxc, 1);
   endtask

   task automatic do_reset();
      rst = 1; step(2); rst = 0; step(1);
   endtask

   function automatic logic [7:0] ld(input int i);
      return i < log_d.size() ? log_d[i] : 8'hxx;
   endfunction

   initial begin
      int base, pc, at, c0;
      logic [7:0] rr_exp [4];
      rr_exp = '{8'h10, 8'h20, 8'h11, 8'h21};
      step(2);
      chk("rst_start", tx_start, 0); chk("rst_data", tx_data, 8'h00); chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0); chk("rst_full", {ch1_full, ch0_full}, 0); chk("rst_ovf", ovf, 0);
      fork
         forever begin
            @(negedge clk);
            chk("start", tx_start, m_start); chk("data", tx_data, m_data); chk("grant", grant, m_grant);
            chk("busy", busy, m_out); chk("ovf", ovf, m_ovf);
            chk("full0", ch0_full, mq0.size() == DEPTH); chk("full1", ch1_full, mq1.size() == DEPTH);
         end
      join_none
      rst = 0; step(1);
      // single byte with long transmitter delay
      tx_delay = 100; tx_hold = 2; base = log_d.size(); pc = cyc;
      drive(1, 8'h41, 0, 0);
      wait_idle(300, at);
      chk("single_count", log_d.size() - base, 1); chk("single_data", ld(base), 8'h41);
      chk("single_grant", log_g[base], 0); chk("single_latency", log_c[base] - pc, 2);
      chk("single_busy_drop", at - fall_cyc, 1);
      step(2);
      // round-robin tie breaking
      do_reset(); tx_delay = 3; tx_hold = 2; base = log_d.size();
      drive(1, 8'h10, 1, 8'h20); drive(1, 8'h11, 1, 8'h21);
      wait_idle(200, at); step(2);
      chk("rr_count", log_d.size() - base, 4);
      for (int i = 0; i < 4; i++) chk("rr_order", ld(base + i), rr_exp[i]);
      // overflow with the transmitter stalled on an in-flight byte
      do_reset(); tx_stall = 1; base = log_d.size();
      drive(0, 0, 1, 8'hEE); step(3);
      for (int i = 1; i <= 5; i++) begin
         ch0_wr = 1; ch0_data = 8'hB0 + 8'(i);
         @(negedge clk);
         if (i == 3) chk("ovf_notfull3", ch0_full, 0);
         if (i == 4) begin chk("ovf_full4", ch0_full, 1); chk("ovf_clear4", ovf, 0); end
      end
      ch0_wr = 0;
      chk("ovf_set5", ovf, 2'b01);
      tx_stall = 0; kick_req++;
      wait_idle(300, at); step(2);
      chk("ovf_count", log_d.size() - base, 5); chk("ovf_first", ld(base), 8'hEE);
      for (int i = 1; i <= 4; i++) chk("ovf_order", ld(base + i), 8'hB0 + 8'(i));
      // sticky end flag: second launch only after the flag has fallen
      do_reset(); tx_delay = 4; tx_hold = 10; base = log_d.size();
      drive(1, 8'h51, 0, 0); drive(1, 8'h52, 0, 0);
      wait_idle(300, at); step(2);
      chk("sticky_count", log_d.size() - base, 2);
      c0 = log_c.size() > base + 1 ? log_c[base + 1] - log_c[base] : -1;
      chk("sticky_gap", c0, 16);
      // asynchronous reset while waiting for the end flag
      do_reset(); tx_stall = 1;
      drive(0, 0, 1, 8'h61); drive(0, 0, 1, 8'h62); drive(0, 0, 1, 8'h63); drive(0, 0, 1, 8'h64);
      step(3);
      chk("mid_busy", busy, 1); chk("mid_grant", grant, 1);
      #2 rst = 1; #1;
      chk("arst_start", tx_start, 0); chk("arst_data", tx_data, 0); chk("arst_busy", busy, 0);
      chk("arst_grant", grant, 0); chk("arst_full", {ch1_full, ch0_full}, 0); chk("arst_ovf", ovf, 0);
      @(negedge clk); step(1); rst = 0; base = log_d.size();
      step(30);
      chk("arst_no_launch", log_d.size() - base, 0);
      tx_stall = 0;
      // pointer wrap on channel 1
      do_reset(); tx_delay = 2; tx_hold = 1; base = log_d.size();
      for (int i = 0; i < 10; i++) begin drive(0, 0, 1, 8'h30 + 8'(i)); wait_idle(100, at); end
      step(2);
      chk("wrap_count", log_d.size() - base, 10);
      for (int i = 0; i < 10; i++) chk("wrap_order", ld(base + i), 8'h30 + 8'(i));
      // random traffic with random transmitter timing
      do_reset(); rnd_tx = 1;
      for (int i = 0; i < 3000; i++)
         drive($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 4) == 0, 8'($urandom));
      wait_idle(2000, at); step(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
